// File: rtl/mjpeg_block_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : mjpeg_block_fetch
//  Purpose  : Memory-mapped block gather engine. The CPU programs SRC, DST,
//             STRIDE and NBLK, then starts a transfer. For each block the
//             engine gathers an 8x2-word tile (8 rows of 2 words, rows STRIDE
//             bytes apart) and writes it to DST as 16 consecutive words.
//  Ports    : clk, resetn (sync, active-low)
//             CPU  : en, valid, addr[31:0], wstrb[3:0], wdata[31:0]
//                    -> ready (1-cycle pulse), rdata[31:0]
//             MEM  : mem_valid, mem_write, mem_addr[31:0], mem_wdata[31:0]
//                    <- mem_ready, mem_rdata[31:0]
//  Registers: 0x00 CTRL (bit0 start), 0x04 STATUS (bit0 busy, bit1 done),
//             0x08 SRC, 0x0C DST, 0x10 STRIDE, 0x14 NBLK, 0x18 PERF
//  Options  : define MJPEG_BLOCK_FETCH_PERF_EN to include the busy-cycle
//             counter behind PERF; otherwise PERF reads 0.
//  Revision : 1.0 - initial release
// ============================================================================
module mjpeg_block_fetch #(
    parameter logic [31:0] MMAP_BASE = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    input  logic        valid,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        mem_valid,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] c_OFF_CTRL   = 32'h00;
    localparam logic [31:0] c_OFF_STATUS = 32'h04;
    localparam logic [31:0] c_OFF_SRC    = 32'h08;
    localparam logic [31:0] c_OFF_DST    = 32'h0C;
    localparam logic [31:0] c_OFF_STRIDE = 32'h10;
    localparam logic [31:0] c_OFF_NBLK   = 32'h14;
    localparam logic [31:0] c_OFF_PERF   = 32'h18;

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_RD      = 3'd1;
    localparam logic [2:0] c_S_RD_WAIT = 3'd2;
    localparam logic [2:0] c_S_WR      = 3'd3;
    localparam logic [2:0] c_S_WR_WAIT = 3'd4;

    logic [31:0] r_src, r_dst, r_stride, r_nblk;
    logic        r_busy, r_done;
    logic [2:0]  r_state;
    logic [31:0] r_blk;
    logic [3:0]  r_word;
    logic        r_ready;
    logic [31:0] r_rdata;
    logic        r_mem_valid, r_mem_write;
    logic [31:0] r_mem_addr, r_mem_wdata;

    logic        w_acc, w_wr, w_start, w_cfg_we;
    logic [31:0] w_off, w_rd_val, w_perf;
    logic        w_last_word, w_last_blk;
    logic [3:0]  w_nxt_word;
    logic [31:0] w_nxt_blk;

    // Row r of block b starts at SRC + 8*b + STRIDE*r; each row holds 2 words.
    function automatic logic [31:0] f_rd_addr(input logic [31:0] src, input logic [31:0] stride,
                                              input logic [28:0] blk, input logic [3:0] word);
        return src + {blk, 3'b000} + (stride * {29'd0, word[3:1]}) + {29'd0, word[0], 2'b00};
    endfunction

    // Destination blocks are packed: 16 words (64 bytes) per block.
    function automatic logic [31:0] f_wr_addr(input logic [31:0] dst, input logic [25:0] blk,
                                              input logic [3:0] word);
        return dst + {blk, 6'd0} + {26'd0, word, 2'b00};
    endfunction

    assign w_acc    = valid && en && !r_ready;
    assign w_wr     = w_acc && (wstrb != 4'b0000);
    assign w_off    = addr - MMAP_BASE;
    assign w_start  = w_wr && (w_off == c_OFF_CTRL) && wdata[0] && !r_busy;
    assign w_cfg_we = w_wr && !r_busy;

    assign w_last_word = (r_word == 4'hF);
    assign w_last_blk  = ((r_blk + 32'd1) == r_nblk);
    assign w_nxt_word  = r_word + 4'd1;
    assign w_nxt_blk   = w_last_word ? (r_blk + 32'd1) : r_blk;

    always_comb begin
        w_rd_val = 32'd0;
        case (w_off)
            c_OFF_STATUS: w_rd_val = {30'd0, r_done, r_busy};
            c_OFF_SRC:    w_rd_val = r_src;
            c_OFF_DST:    w_rd_val = r_dst;
            c_OFF_STRIDE: w_rd_val = r_stride;
            c_OFF_NBLK:   w_rd_val = r_nblk;
            c_OFF_PERF:   w_rd_val = w_perf;
            default:      w_rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_src       <= 32'd0;
            r_dst       <= 32'd0;
            r_stride    <= 32'd0;
            r_nblk      <= 32'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_state     <= c_S_IDLE;
            r_blk       <= 32'd0;
            r_word      <= 4'd0;
            r_ready     <= 1'b0;
            r_rdata     <= 32'd0;
            r_mem_valid <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_ready <= w_acc;
            if (w_acc) begin
                r_rdata <= w_rd_val;
            end

            if (w_cfg_we) begin
                case (w_off)
                    c_OFF_SRC:    r_src    <= wdata;
                    c_OFF_DST:    r_dst    <= wdata;
                    c_OFF_STRIDE: r_stride <= wdata;
                    c_OFF_NBLK:   r_nblk   <= wdata;
                    default:      ;
                endcase
            end

            // Start only lands while idle, so it never overlaps the FSM's
            // own updates of busy/done/blk/word below.
            if (w_start) begin
                r_busy <= 1'b1;
                r_done <= 1'b0;
                r_blk  <= 32'd0;
                r_word <= 4'd0;
            end

            case (r_state)
                c_S_IDLE: begin
                    // One launch cycle with busy set; an empty job finishes here.
                    if (r_busy) begin
                        if (r_nblk == 32'd0) begin
                            r_busy <= 1'b0;
                            r_done <= 1'b1;
                        end else begin
                            r_state     <= c_S_RD;
                            r_mem_valid <= 1'b1;
                            r_mem_write <= 1'b0;
                            r_mem_addr  <= f_rd_addr(r_src, r_stride, r_blk[28:0], r_word);
                        end
                    end
                end
                c_S_RD: begin
                    r_mem_valid <= 1'b0;
                    r_state     <= c_S_RD_WAIT;
                end
                c_S_RD_WAIT: begin
                    if (mem_ready) begin
                        r_mem_wdata <= mem_rdata;
                        r_mem_valid <= 1'b1;
                        r_mem_write <= 1'b1;
                        r_mem_addr  <= f_wr_addr(r_dst, r_blk[25:0], r_word);
                        r_state     <= c_S_WR;
                    end
                end
                c_S_WR: begin
                    r_mem_valid <= 1'b0;
                    r_state     <= c_S_WR_WAIT;
                end
                c_S_WR_WAIT: begin
                    if (mem_ready) begin
                        if (w_last_word && w_last_blk) begin
                            r_state <= c_S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_word      <= w_nxt_word;
                            r_blk       <= w_nxt_blk;
                            r_state     <= c_S_RD;
                            r_mem_valid <= 1'b1;
                            r_mem_write <= 1'b0;
                            r_mem_addr  <= f_rd_addr(r_src, r_stride, w_nxt_blk[28:0], w_nxt_word);
                        end
                    end
                end
                default: begin
                    r_state     <= c_S_IDLE;
                    r_mem_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MJPEG_BLOCK_FETCH_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_perf <= 32'd0;
        end else if (w_start) begin
            r_perf <= 32'd0;
        end else if (r_busy && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign w_perf = r_perf;
`else
    assign w_perf = 32'd0;
`endif

    assign ready     = r_ready;
    assign rdata     = r_rdata;
    assign mem_valid = r_mem_valid;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire
